// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetcher
// Purpose  : Fetch-PC owner and Cache requester feeding a small in-order
//            instruction queue drained by the decoder (valid/ready).
// Options  : IFETCH_JAL_REDIRECT_EN - follow JAL targets when computing next PC
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetcher #(
    parameter int unsigned IQ_DEPTH_LOG2 = 2,
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear_up,
    input  logic [31:0]              flush_pc,
    output logic                     start_fetch,
    output logic [31:0]              pc,
    input  logic                     fetch_ready,
    input  logic [31:0]              inst,
    input  logic [31:0]              inst_addr,
    output logic                     iq_valid,
    output logic [31:0]              iq_inst,
    output logic [31:0]              iq_pc,
    input  logic                     dec_ready,
    output logic [IQ_DEPTH_LOG2:0]   iq_count
);

    localparam int unsigned              c_iq_depth   = 1 << IQ_DEPTH_LOG2;
    localparam logic [IQ_DEPTH_LOG2:0]   c_count_full = (IQ_DEPTH_LOG2 + 1)'(c_iq_depth);
    localparam logic [IQ_DEPTH_LOG2:0]   c_count_one  = (IQ_DEPTH_LOG2 + 1)'(1);
    localparam logic [IQ_DEPTH_LOG2-1:0] c_ptr_one    = (IQ_DEPTH_LOG2)'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [31:0]              r_pc;
    logic [31:0]              w_next_pc;
    logic [IQ_DEPTH_LOG2-1:0] r_head;
    logic [IQ_DEPTH_LOG2-1:0] r_tail;
    logic [IQ_DEPTH_LOG2:0]   r_count;
    logic [IQ_DEPTH_LOG2:0]   w_count_next;
    logic [31:0]              r_iq_inst [c_iq_depth];
    logic [31:0]              r_iq_pc   [c_iq_depth];
    logic                     w_valid;
    logic                     w_push;
    logic                     w_pop;

    assign w_valid = (r_count != '0);

    // A return only counts when it matches the outstanding request address.
    assign w_push = rdy_in & ~rob_clear_up & (r_state == ST_WAIT)
                  & fetch_ready & (inst_addr == r_pc);
    assign w_pop  = rdy_in & ~rob_clear_up & w_valid & dec_ready;

`ifdef IFETCH_JAL_REDIRECT_EN
    logic [31:0] w_jal_imm;
    assign w_jal_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_next_pc = (inst[6:0] == 7'b1101111) ? (r_pc + w_jal_imm) : (r_pc + 32'd4);
`else
    assign w_next_pc = r_pc + 32'd4;
`endif

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_count_one;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_count_one;
        end
    end

    always_comb begin
        w_state_next = r_state;
        start_fetch  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count < c_count_full) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                start_fetch = 1'b1;
                if (w_push) begin
                    w_state_next = (w_count_next < c_count_full) ? ST_WAIT : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Flush wins even while frozen; otherwise a low rdy_in holds the state.
        if (rob_clear_up) begin
            w_state_next = ST_IDLE;
        end else if (!rdy_in) begin
            w_state_next = r_state;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rob_clear_up) begin
            r_pc    <= flush_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (w_push) begin
                r_tail <= r_tail + c_ptr_one;
                r_pc   <= w_next_pc;
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_one;
            end
            r_count <= w_count_next;
        end
    end

    // Queue storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_iq_inst[r_tail] <= inst;
            r_iq_pc[r_tail]   <= r_pc;
        end
    end

    assign pc       = r_pc;
    assign iq_valid = w_valid;
    assign iq_inst  = w_valid ? r_iq_inst[r_head] : '0;
    assign iq_pc    = w_valid ? r_iq_pc[r_head]   : '0;
    assign iq_count = r_count;

endmodule
`default_nettype wire
